// File: rtl/med_window_sched.sv
// Row-window scheduler for the 3x3 median: keeps a top/mid/bot row window, one window per output row.
// Edge rows are replicated at frame top and bottom; flow is valid/ready on both sides with SET restart.
module med_window_sched #(
  parameter int ROW   = 512,
  parameter int COL   = 512,
  parameter int width = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROW*width-1:0]   row_in,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [ROW*width-1:0]   win_top,
  output logic [ROW*width-1:0]   win_mid,
  output logic [ROW*width-1:0]   win_bot,
  output logic [$clog2(COL)-1:0] win_row,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int RW = $clog2(COL);
  localparam logic [RW-1:0] LAST = RW'(COL - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ROW*width-1:0] top_q, top_d;
  logic [ROW*width-1:0] mid_q, mid_d;
  logic [ROW*width-1:0] bot_q, bot_d;
  logic                 win_valid_q, win_valid_d;
  logic [RW-1:0]        win_row_q, win_row_d;
  logic [RW-1:0]        in_cnt_q, in_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 acc, take;

  // SET wins over any handshake, so the input is refused in that cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!SET) begin
      case (state_q)
        S_FILL:   in_ready = 1'b1;
        S_STREAM: in_ready = !win_valid_q || win_ready;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign acc  = in_valid && in_ready;
  assign take = win_valid_q && win_ready;

  always_comb begin
    state_d      = state_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    win_valid_d  = win_valid_q;
    win_row_d    = win_row_q;
    in_cnt_d     = in_cnt_q;
    frame_done_d = 1'b0;
    if (SET) begin
      state_d     = S_FILL;
      win_valid_d = 1'b0;
      in_cnt_d    = '0;
      win_row_d   = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (acc) begin
            top_d    = row_in;
            mid_d    = row_in;
            bot_d    = row_in;
            in_cnt_d = RW'(1);
            state_d  = S_STREAM;
          end
        end
        S_STREAM: begin
          if (acc) begin
            top_d       = mid_q;
            mid_d       = bot_q;
            bot_d       = row_in;
            win_valid_d = 1'b1;
            win_row_d   = in_cnt_q - RW'(1);
            // Counter saturates at the last row; the flush window is tracked via win_row.
            if (in_cnt_q == LAST) begin
              state_d = S_FLUSH;
            end else begin
              in_cnt_d = in_cnt_q + RW'(1);
            end
          end else if (take) begin
            win_valid_d = 1'b0;
          end
        end
        S_FLUSH: begin
          if (take) begin
            if (win_row_q == LAST) begin
              win_valid_d  = 1'b0;
              frame_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              top_d     = mid_q;
              mid_d     = bot_q;
              win_row_d = LAST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      in_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      in_cnt_q     <= in_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_top    = top_q;
  assign win_mid    = mid_q;
  assign win_bot    = bot_q;
  assign win_row    = win_row_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_med_window_sched.sv
// Random and directed frames against a window-sequence model; a second COL=2 instance covers the short frame.
module tb_med_window_sched;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int W  = 8;
  localparam int RB = R * W;

  logic          CLK, RST, SET, in_valid, in_ready, win_valid, win_ready, frame_done, busy;
  logic [RB-1:0] row_in, win_top, win_mid, win_bot;
  logic [1:0]    win_row;

  logic          set2, in_valid2, in_ready2, win_valid2, win_ready2, frame_done2, busy2;
  logic [RB-1:0] row_in2, win_top2, win_mid2, win_bot2;
  logic [0:0]    win_row2;

  int n_chk = 0;
  int n_err = 0;
  logic [RB-1:0] rows [C];

  med_window_sched #(.ROW(R), .COL(C), .width(W)) dut (
    .CLK(CLK), .RST(RST), .SET(SET), .in_valid(in_valid), .in_ready(in_ready),
    .row_in(row_in), .win_valid(win_valid), .win_ready(win_ready),
    .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot), .win_row(win_row),
    .frame_done(frame_done), .busy(busy)
  );

  med_window_sched #(.ROW(R), .COL(2), .width(W)) dut2 (
    .CLK(CLK), .RST(RST), .SET(set2), .in_valid(in_valid2), .in_ready(in_ready2),
    .row_in(row_in2), .win_valid(win_valid2), .win_ready(win_ready2),
    .win_top(win_top2), .win_mid(win_mid2), .win_bot(win_bot2), .win_row(win_row2),
    .frame_done(frame_done2), .busy(busy2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int up(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

  function automatic int dn(input int n, input int ncol);
    return (n < ncol - 1) ? n + 1 : ncol - 1;
  endfunction

  function automatic logic [RB-1:0] pat(input int k);
    return {R{8'(k + 1)}};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    check({tag, "_win_top"}, 64'(win_top), 64'd0);
    check({tag, "_win_mid"}, 64'(win_mid), 64'd0);
    check({tag, "_win_bot"}, 64'(win_bot), 64'd0);
    check({tag, "_win_row"}, 64'(win_row), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Model: window r is (rows[r-1], rows[r], rows[r+1]) with clamped indices, presented in order.
  // Window r exists once row r+1 is in, or once the whole frame is in.
  task automatic run_frame(input bit do_set, input int pv, input int pr, input int stall_row,
                           input int abort_at, input bit timing_chk);
    int nr, nt, cyc, first_acc, stall_left;
    bit acc, take, last_take, fin, exp_wv, exp_rdy;
    nr = 0; nt = 0; cyc = 0; first_acc = -1; stall_left = 3; last_take = 0; fin = 0;
    if (do_set) begin
      SET = 1'b1; in_valid = 1'b0;
      @(posedge CLK); #1;
      SET = 1'b0;
    end
    while (!fin && cyc < 400) begin
      in_valid  = ($urandom_range(99) < pv);
      row_in    = (nr < C) ? rows[nr] : RB'($urandom);
      win_ready = ($urandom_range(99) < pr);
      if (stall_row >= 0 && win_valid && int'(win_row) == stall_row && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end
      @(negedge CLK);
      exp_wv  = (nt < nr - 1) || (nr == C && nt < C);
      exp_rdy = (nr < C) && (nr == 0 || !exp_wv || win_ready);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("win_valid", 64'(win_valid), 64'(exp_wv));
      check("frame_done", 64'(frame_done), 64'(last_take));
      if (exp_wv) begin
        check("win_row", 64'(win_row), 64'(nt));
        check("win_top", 64'(win_top), 64'(rows[up(nt)]));
        check("win_mid", 64'(win_mid), 64'(rows[nt]));
        check("win_bot", 64'(win_bot), 64'(rows[dn(nt, C)]));
      end
      // The first accept edge closes its iteration, so 1+COL edges later is COL+2 iterations on.
      if (timing_chk && last_take) check("done_latency", 64'(cyc - first_acc), 64'(C + 2));
      if (last_take) fin = 1'b1;
      acc  = in_valid && exp_rdy;
      take = exp_wv && win_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      last_take = take && (nt == C - 1);
      nr += int'(acc);
      nt += int'(take);
      @(posedge CLK); #1;
      cyc++;
      if (abort_at > 0 && nr == abort_at) fin = 1'b1;
    end
    check("frame_end", 64'(fin), 64'd1);
    in_valid = 1'b0;
    if (abort_at == 0) begin
      @(negedge CLK);
      check("done_once", 64'(frame_done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int k2, ndone;
    logic [RB-1:0] q_top[$], q_mid[$], q_bot[$];
    int q_row[$];

    RST = 1'b0; SET = 1'b0; in_valid = 1'b0; win_ready = 1'b0; row_in = '0;
    set2 = 1'b0; in_valid2 = 1'b0; win_ready2 = 1'b0; row_in2 = '0;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // IDLE ignores input.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; row_in = pat(i);
      @(negedge CLK);
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_win_valid", 64'(win_valid), 64'd0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;

    for (int k = 0; k < C; k++) rows[k] = pat(k);
    run_frame(1'b1, 100, 100, -1, 0, 1'b1);
    run_frame(1'b1, 100, 100, 1, 0, 1'b0);

    // SET after three rows; the row offered alongside SET must be refused.
    run_frame(1'b1, 100, 100, -1, 3, 1'b0);
    SET = 1'b1; in_valid = 1'b1; row_in = pat(3); win_ready = 1'b0;
    @(negedge CLK);
    check("set_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    SET = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    check("set_win_valid", 64'(win_valid), 64'd0);
    check("set_win_row", 64'(win_row), 64'd0);
    check("set_fill_busy", 64'(busy), 64'd1);
    check("set_fill_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    run_frame(1'b0, 100, 100, -1, 0, 1'b0);

    for (int f = 0; f < 15; f++) begin
      for (int k = 0; k < C; k++) rows[k] = RB'($urandom);
      run_frame(1'b1, 40 + int'($urandom_range(60)), 30 + int'($urandom_range(70)), -1, 0, 1'b0);
    end

    // Reset mid-frame.
    for (int k = 0; k < C; k++) rows[k] = pat(k);
    run_frame(1'b1, 100, 100, -1, 3, 1'b0);
    #3 RST = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; win_ready = 1'b1; row_in = pat(i);
      @(negedge CLK);
      check("post_rst_win_valid", 64'(win_valid), 64'd0);
      check("post_rst_frame_done", 64'(frame_done), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;

    // COL=2 frame on the second instance.
    set2 = 1'b1;
    @(posedge CLK); #1;
    set2 = 1'b0; win_ready2 = 1'b1; k2 = 0; ndone = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid2 = (k2 < 2);
      row_in2   = pat(k2);
      @(negedge CLK);
      if (in_valid2 && in_ready2) k2++;
      if (win_valid2) begin
        q_top.push_back(win_top2); q_mid.push_back(win_mid2);
        q_bot.push_back(win_bot2); q_row.push_back(int'(win_row2));
      end
      if (frame_done2) ndone++;
      @(posedge CLK); #1;
    end
    in_valid2 = 1'b0;
    check("c2_windows", 64'(q_row.size()), 64'd2);
    for (int r = 0; r < 2 && r < q_row.size(); r++) begin
      check("c2_row", 64'(q_row[r]), 64'(r));
      check("c2_top", 64'(q_top[r]), 64'(pat(up(r))));
      check("c2_mid", 64'(q_mid[r]), 64'(pat(r)));
      check("c2_bot", 64'(q_bot[r]), 64'(pat(dn(r, 2))));
    end
    check("c2_frame_done", 64'(ndone), 64'd1);
    check("c2_idle", 64'(busy2), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
